ascii_string_serializer: RTL and testbench
==========================================

# ascii_string_serializer

Upstream feeder for the ASCII converter. Accepts a packed string in Verilog string-literal layout (right-justified, first character in the highest occupied byte) and streams it one byte per cycle over a valid/ready handshake. Its byte output drives the converter's `data_in`, replacing whole-string assignments with a proper character stream. Supports explicit or auto-detected length, backpressure and abort.

## Interface
- `MAX_CHARS`, default 16: capacity in characters. `load_str` is 8*MAX_CHARS bits wide.
- `LEN_W`, default $clog2(MAX_CHARS+1): width of `load_len`.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `load_valid`  in  1  load request.
- `load_ready`  out  1  high only in IDLE; a load is accepted when `load_valid && load_ready`.
- `load_str`  in  8*MAX_CHARS  packed string. Byte k occupies bits [8k+7:8k]. Byte 0 is the last character.
- `load_len`  in  LEN_W  number of characters. 0 means auto-detect.
- `abort`  in  1  synchronous abort of the current string.
- `char_valid`  out  1  `char_data` holds a valid character.
- `char_ready`  in  1  the consumer accepts the character.
- `char_data`  out  8  current character byte.
- `char_last`  out  1  qualifies the final character of the string.
- `done`  out  1  one-cycle pulse at the end of a string.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, LOAD, SEND.
- IDLE, on load accept:
  - register `load_str` and `load_len`.
  - go to LOAD.
- LOAD (one cycle):
  - Compute the effective length L.
  - If `load_len` is non-zero: L = min(`load_len`, MAX_CHARS).
  - If `load_len` is 0: L = 1 + the index of the highest non-NUL (≠8'h00) byte, or 0 if all bytes are NUL.
  - If L = 0: pulse `done` and return to IDLE. `char_valid` is never raised.
  - Otherwise: set index i = L-1 and go to SEND.
- SEND:
  - `char_data` = byte i of the registered string.
  - `char_valid` = 1.
  - `char_last` = (i == 0).
  - On each `char_valid && char_ready`:
    - if i > 0: decrement i.
    - if i == 0: go to IDLE and pulse `done`.
- Embedded NUL bytes below the detected top byte are emitted unchanged.
- Abort:
  - Takes effect in any non-IDLE state.
  - Next state is IDLE; `char_valid`, `char_last` and `busy` are 0 from the next cycle.
  - `done` is not pulsed.
  - Abort has priority over a simultaneous handshake; that character counts as not delivered.
- Reset:
  - Asynchronous.
  - Forces IDLE and i = 0.
  - `char_valid` = 0, `char_data` = 8'h00, `char_last` = 0, `done` = 0, `busy` = 0.
  - `load_ready` = 1 (decoded from IDLE), so it is 1 during and after reset.
  - Reset mid-string discards the string with no `done`.

## Timing
- Latency: load accepted in cycle N → LOAD in N+1 → first `char_valid` in N+2.
- Throughput: one character per cycle while `char_ready` is held high; no bubbles between characters.
- Backpressure: while `char_valid && !char_ready`, `char_data` and `char_last` stay stable and `char_valid` stays high. Abort is the only exception.
- `done` is high in the cycle after the final handshake, with the state already IDLE. `load_ready` is 1 in that same cycle.
- A new load can be accepted in the `done` cycle.
- Empty string: `done` is high in cycle N+2, `char_valid` stays 0 throughout, and `load_ready` is 1 again in N+2.
- All outputs are registered except `load_ready` and `busy`, which are decoded from the state register.

## Structure
- Package `ascii_pkg`:
  - state enum {IDLE, LOAD, SEND}.
  - `CHAR_W` = 8.
  - `ASCII_NUL` = 8'h00.
- One sub-module, `ascii_len_finder`: a combinational priority encoder. Input is the registered string; outputs are the auto length and an all-NUL flag.

## Test plan
- Auto length, no backpressure: "PUC-Minas" packed with `load_len` = 0 and `char_ready` = 1.
  - Required: 9 characters P,U,C,-,M,i,n,a,s in consecutive cycles starting at N+2.
  - `char_last` only on 's'; `done` in the following cycle.
- Backpressure: "2023-02" with `load_len` = 7 and `char_ready` toggling 1,0,0,1….
  - Required: exactly 7 characters in order.
  - `char_data` stays stable across every stalled cycle; no duplicates or drops.
- Explicit length: "Belo" packed with `load_len` = 3.
  - Required: 'e','l','o' emitted and 'B' never emitted.
- Clamp: MAX_CHARS = 16, `load_len` = 20, full 16-byte string.
  - Required: exactly 16 characters, `char_last` on byte 0.
- Empty string: all-zero `load_str` with `load_len` = 0.
  - Required: no `char_valid`; `done` in N+2; `load_ready` high in N+2.
- Abort and reset during "Belo Horizonte":
  - `abort` on the 4th character → `char_valid` = 0 next cycle, no `done`, the next load is accepted.
  - A repeat run with `rst_n` low mid-string → all outputs immediately at their reset values.

Source files
------------

// File: rtl/ascii_pkg.sv
// Shared types and constants for the ASCII string serializer.
package ascii_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam logic [CHAR_W-1:0] ASCII_NUL = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

endpackage

// File: rtl/ascii_string_serializer_if.sv
// Load request and character stream handshake bundle for the serializer.
interface ascii_string_serializer_if
  import ascii_pkg::*;
#(
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned LEN_W     = $clog2(MAX_CHARS + 1)
) ();

  logic                          load_valid;
  logic                          load_ready;
  logic [CHAR_W*MAX_CHARS-1:0]   load_str;
  logic [LEN_W-1:0]              load_len;
  logic                          abort;
  logic                          char_valid;
  logic                          char_ready;
  logic [CHAR_W-1:0]             char_data;
  logic                          char_last;
  logic                          done;
  logic                          busy;

  modport master (
    output load_valid, load_str, load_len, abort, char_ready,
    input  load_ready, char_valid, char_data, char_last, done, busy
  );

  modport slave (
    input  load_valid, load_str, load_len, abort, char_ready,
    output load_ready, char_valid, char_data, char_last, done, busy
  );

endinterface

// File: rtl/ascii_len_finder.sv
// Priority encoder: length of a right-justified string up to its highest non-NUL byte.
module ascii_len_finder
  import ascii_pkg::*;
#(
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic [CHAR_W*MAX_CHARS-1:0] str,
  output logic [LEN_W-1:0]            auto_len,
  output logic                        all_nul
);

  // Later (higher) bytes overwrite earlier hits, so the topmost non-NUL wins.
  always_comb begin
    auto_len = '0;
    all_nul  = 1'b1;
    for (int unsigned k = 0; k < MAX_CHARS; k++) begin
      if (str[k*CHAR_W +: CHAR_W] != ASCII_NUL) begin
        auto_len = LEN_W'(k + 1);
        all_nul  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ascii_string_serializer.sv
// Streams a packed string-literal-layout string one byte per cycle, top byte first.
module ascii_string_serializer
  import ascii_pkg::*;
#(
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input logic                     clk,
  input logic                     rst_n,
  ascii_string_serializer_if.slave bus
);

  localparam int unsigned STR_W = CHAR_W * MAX_CHARS;
  localparam int unsigned IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  state_t             state;
  logic [STR_W-1:0]   str_q;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   idx;
  logic [LEN_W-1:0]   auto_len;
  logic               all_nul;
  logic [LEN_W-1:0]   eff_len;
  logic [IDX_W-1:0]   top_idx;
  logic               empty;

  function automatic logic [CHAR_W-1:0] byte_at(input logic [STR_W-1:0] s,
                                                input logic [IDX_W-1:0] i);
    return s[32'(i)*CHAR_W +: CHAR_W];
  endfunction

  ascii_len_finder #(
    .MAX_CHARS (MAX_CHARS),
    .LEN_W     (LEN_W)
  ) u_len_finder (
    .str      (str_q),
    .auto_len (auto_len),
    .all_nul  (all_nul)
  );

  // Effective length: explicit length clamped to capacity, else auto-detected.
  always_comb begin
    eff_len = auto_len;
    if (len_q != '0) begin
      eff_len = (len_q > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : len_q;
    end
    empty   = (len_q == '0) && all_nul;
    top_idx = IDX_W'(eff_len - LEN_W'(1));
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      str_q          <= '0;
      len_q          <= '0;
      idx            <= '0;
      bus.char_valid <= 1'b0;
      bus.char_data  <= ASCII_NUL;
      bus.char_last  <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load_valid) begin
            str_q <= bus.load_str;
            len_q <= bus.load_len;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (empty) begin
            bus.done <= 1'b1;
            state    <= IDLE;
          end else begin
            idx            <= top_idx;
            bus.char_data  <= byte_at(str_q, top_idx);
            bus.char_valid <= 1'b1;
            bus.char_last  <= (top_idx == '0);
            state          <= SEND;
          end
        end
        SEND: begin
          // Abort wins over a same-cycle handshake; that character is dropped.
          if (bus.abort) begin
            bus.char_valid <= 1'b0;
            bus.char_last  <= 1'b0;
            state          <= IDLE;
          end else if (bus.char_ready) begin
            if (idx == '0) begin
              bus.char_valid <= 1'b0;
              bus.char_last  <= 1'b0;
              bus.done       <= 1'b1;
              state          <= IDLE;
            end else begin
              idx           <= idx - IDX_W'(1);
              bus.char_data <= byte_at(str_q, idx - IDX_W'(1));
              bus.char_last <= (idx == IDX_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_string_serializer.sv
// Self-checking bench: directed strings plus randomized traffic against a queue-based model.
module tb_ascii_string_serializer;
  import ascii_pkg::*;

  localparam int unsigned MAXC = 16;
  localparam int unsigned LW   = $clog2(MAXC + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascii_string_serializer_if #(.MAX_CHARS(MAXC), .LEN_W(LW)) bus ();

  ascii_string_serializer #(.MAX_CHARS(MAXC), .LEN_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   m_q[$];
  bit           m_loading = 0;
  bit           m_sending = 0;
  bit           m_done    = 0;
  logic [127:0] m_str;
  int           m_len;

  function automatic int exp_len(input logic [127:0] s, input int len);
    int l = 0;
    if (len != 0) return (len > int'(MAXC)) ? int'(MAXC) : len;
    for (int k = 0; k < int'(MAXC); k++) if (s[k*8 +: 8] != 8'h00) l = k + 1;
    return l;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_loading = 0;
      m_sending = 0;
      m_done    = 0;
    end else begin
      m_done = 0;
      if (bus.abort && (m_loading || m_sending)) begin
        m_loading = 0;
        m_sending = 0;
        m_q.delete();
      end else if (m_loading) begin
        int l;
        l = exp_len(m_str, m_len);
        m_loading = 0;
        for (int k = l - 1; k >= 0; k--) m_q.push_back(m_str[k*8 +: 8]);
        if (l == 0) m_done = 1;
        else m_sending = 1;
      end else if (m_sending) begin
        if (bus.char_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_sending = 0;
            m_done    = 1;
          end
        end
      end else if (bus.load_valid) begin
        m_str     = bus.load_str;
        m_len     = int'(bus.load_len);
        m_loading = 1;
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      bit idle;
      idle = !(m_loading || m_sending);
      check("load_ready", 128'(bus.load_ready), 128'(idle));
      check("busy",       128'(bus.busy),       128'(!idle));
      check("char_valid", 128'(bus.char_valid), 128'(m_sending));
      check("done",       128'(bus.done),       128'(m_done));
      if (m_sending && m_q.size() > 0) begin
        check("char_data", 128'(bus.char_data), 128'(m_q[0]));
        check("char_last", 128'(bus.char_last), 128'(m_q.size() == 1));
      end
    end
  end

  // ---------------- observation monitor ----------------
  int           cyc = 0;
  int           acc_cyc, first_v_cyc, done_cyc, done_cnt, del_n, last_cyc;
  logic [127:0] del_str;
  logic         lr_at_done;
  logic [7:0]   last_char;
  bit           abort_fired;

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.load_valid && bus.load_ready) acc_cyc = cyc;
      if (bus.char_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (bus.done) begin
        done_cyc   = cyc;
        done_cnt++;
        lr_at_done = bus.load_ready;
      end
      if (bus.abort && bus.busy) abort_fired = 1;
      else if (bus.char_valid && bus.char_ready) begin
        del_str = {del_str[119:0], bus.char_data};
        del_n++;
        if (bus.char_last) begin
          last_char = bus.char_data;
          last_cyc  = cyc;
        end
      end
    end
    cyc++;
  end

  task automatic clear_mon();
    acc_cyc     = -100;
    first_v_cyc = -1;
    done_cyc    = -100;
    done_cnt    = 0;
    del_n       = 0;
    last_cyc    = -100;
    del_str     = '0;
    lr_at_done  = 1'b0;
    last_char   = 8'h00;
    abort_fired = 0;
  endtask

  // ---------------- consumer / abort driver ----------------
  int rdy_mode   = 0;
  int rdy_phase  = 0;
  int abort_at   = 0;
  bit rand_abort = 0;

  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.char_ready = 1'b1;
      1:       bus.char_ready = (rdy_phase % 3 == 0);
      default: bus.char_ready = 1'($urandom_range(0, 1));
    endcase
    rdy_phase++;
    bus.abort = (abort_at > 0 && bus.char_valid && del_n == abort_at - 1) ||
                (rand_abort && $urandom_range(0, 40) == 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [127:0] s, input int len);
    int t = 0;
    while (!bus.load_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("load_accept");
    bus.load_valid = 1'b1;
    bus.load_str   = s;
    bus.load_len   = LW'(len);
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) timeout("wait_idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s;
    int n, len, t;

    bus.load_valid = 1'b0;
    bus.load_str   = '0;
    bus.load_len   = '0;
    clear_mon();

    #1;
    check("rst_char_valid", 128'(bus.char_valid), 128'(0));
    check("rst_char_data",  128'(bus.char_data),  128'(0));
    check("rst_char_last",  128'(bus.char_last),  128'(0));
    check("rst_done",       128'(bus.done),       128'(0));
    check("rst_busy",       128'(bus.busy),       128'(0));
    check("rst_load_ready", 128'(bus.load_ready), 128'(1));
    #22 rst_n = 1'b1;
    @(negedge clk);

    // Auto length, no backpressure
    clear_mon();
    rdy_mode = 0;
    do_load("PUC-Minas", 0);
    wait_idle();
    @(negedge clk);
    check("puc_count",   128'(del_n),       128'(9));
    check("puc_string",  del_str,           "PUC-Minas");
    check("puc_latency", 128'(first_v_cyc), 128'(acc_cyc + 2));
    check("puc_burst",   128'(last_cyc - first_v_cyc), 128'(8));
    check("puc_last",    128'(last_char),   128'("s"));
    check("puc_done_at", 128'(done_cyc),    128'(last_cyc + 1));
    check("puc_done_n",  128'(done_cnt),    128'(1));

    // Backpressure 1,0,0 pattern
    clear_mon();
    rdy_mode  = 1;
    rdy_phase = 0;
    do_load("2023-02", 7);
    wait_idle();
    @(negedge clk);
    check("bp_count",  128'(del_n),    128'(7));
    check("bp_string", del_str,        "2023-02");
    check("bp_done_n", 128'(done_cnt), 128'(1));

    // Explicit length shorter than the string
    clear_mon();
    rdy_mode = 0;
    do_load("Belo", 3);
    wait_idle();
    @(negedge clk);
    check("len3_count",  128'(del_n), 128'(3));
    check("len3_string", del_str,     "elo");

    // Explicit length above capacity clamps
    clear_mon();
    do_load("0123456789ABCDEF", 20);
    wait_idle();
    @(negedge clk);
    check("clamp_count",  128'(del_n),     128'(16));
    check("clamp_string", del_str,         "0123456789ABCDEF");
    check("clamp_last",   128'(last_char), 128'("F"));

    // Empty string
    clear_mon();
    do_load('0, 0);
    wait_idle();
    @(negedge clk);
    check("empty_no_valid", 128'(first_v_cyc), 128'(-1));
    check("empty_done_at",  128'(done_cyc),    128'(acc_cyc + 2));
    check("empty_ready",    128'(lr_at_done),  128'(1));
    check("empty_done_n",   128'(done_cnt),    128'(1));

    // Abort on the 4th character
    clear_mon();
    abort_at = 4;
    do_load("Belo Horizonte", 0);
    t = 0;
    while (!abort_fired && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("abort_fire");
    abort_at = 0;
    check("abort_valid", 128'(bus.char_valid), 128'(0));
    check("abort_busy",  128'(bus.busy),       128'(0));
    repeat (3) @(negedge clk);
    check("abort_no_done", 128'(done_cnt), 128'(0));
    check("abort_partial", del_str,        "Bel");
    do_load("Belo", 0);
    wait_idle();
    @(negedge clk);
    check("after_abort_done", 128'(done_cnt), 128'(1));
    check("after_abort_str",  del_str,        "BelBelo");

    // Reset in the middle of a string
    clear_mon();
    do_load("Belo Horizonte", 0);
    t = 0;
    while (del_n < 5 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("mid_string");
    #2 rst_n = 1'b0;
    #1;
    check("mrst_char_valid", 128'(bus.char_valid), 128'(0));
    check("mrst_char_data",  128'(bus.char_data),  128'(0));
    check("mrst_char_last",  128'(bus.char_last),  128'(0));
    check("mrst_done",       128'(bus.done),       128'(0));
    check("mrst_busy",       128'(bus.busy),       128'(0));
    check("mrst_load_ready", 128'(bus.load_ready), 128'(1));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("mrst_no_done", 128'(done_cnt), 128'(0));

    // Randomized traffic, back-to-back loads, random backpressure, later random aborts
    rdy_mode = 2;
    for (int it = 0; it < 60; it++) begin
      rand_abort = (it >= 30);
      s = '0;
      n = $urandom_range(0, 16);
      if ($urandom_range(0, 9) != 0) begin
        for (int k = 0; k < n; k++) begin
          if ($urandom_range(0, 7) == 0) s[k*8 +: 8] = 8'h00;
          else s[k*8 +: 8] = 8'($urandom_range(1, 255));
        end
      end
      len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
      do_load(s, len);
      wait_idle();
    end
    rand_abort = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
